// File: rtl/wb_grf_pkg.sv
// Shared constants and write-back decode for the wb_grf writeback stage:
// MIPS opcode/funct values, write-data source select, and the destination decoder.
package wb_grf_pkg;

  localparam logic [4:0] RA = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [1:0] {WD_ALU, WD_MEM, WD_PC8} wdsel_e;
  typedef enum logic [2:0] {LD_W, LD_H, LD_HU, LD_B, LD_BU} ld_type_e;

  typedef struct packed {
    logic     we;
    logic [4:0] wa;
    wdsel_e   wdsel;
    ld_type_e ld_type;
  } wb_dec_t;

  // Destination and data source of the W-stage instruction; wa may still be 0.
  function automatic wb_dec_t decode(input logic [31:0] instr);
    wb_dec_t    d;
    logic [5:0] op;
    logic [5:0] funct;
    op         = instr[31:26];
    funct      = instr[5:0];
    d.we       = 1'b0;
    d.wa       = 5'd0;
    d.wdsel    = WD_ALU;
    d.ld_type  = LD_W;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA: begin
            d.we = 1'b1;
            d.wa = instr[15:11];
          end
          F_JALR: begin
            d.we    = 1'b1;
            d.wa    = instr[15:11];
            d.wdsel = WD_PC8;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU: begin
        d.we = 1'b1;
        d.wa = instr[20:16];
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        d.we    = 1'b1;
        d.wa    = instr[20:16];
        d.wdsel = WD_MEM;
        case (op)
          OP_LB:   d.ld_type = LD_B;
          OP_LBU:  d.ld_type = LD_BU;
          OP_LH:   d.ld_type = LD_H;
          OP_LHU:  d.ld_type = LD_HU;
          default: d.ld_type = LD_W;
        endcase
      end
      OP_JAL: begin
        d.we    = 1'b1;
        d.wa    = RA;
        d.wdsel = WD_PC8;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wb_grf_load_ext.sv
// Load extender: picks the byte/halfword lane addressed by the low address
// bits and sign- or zero-extends it to 32 bits.
module wb_grf_load_ext
  import wb_grf_pkg::*;
(
  input  ld_type_e    ld_type,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misaligned halfword offsets fall back to the lane at offset & 2.
  assign byte_sel = rdata[{byte_off, 3'b000} +: 8];
  assign half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = rdata;
    case (ld_type)
      LD_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   ld_data = {24'd0, byte_sel};
      LD_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   ld_data = {16'd0, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage and 32x32 general register file with two async read ports.
// Optional macro GRF_BYPASS_EN: same-cycle write-through from W onto the read ports.
module wb_grf
  import wb_grf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_W,
  input  logic [31:0] pc_W,
  input  logic [31:0] ALUOut_W,
  input  logic [31:0] ReadData_W,
  input  logic [4:0]  A1_D,
  input  logic [4:0]  A2_D,
  output logic [31:0] RD1_D,
  output logic [31:0] RD2_D,
  output logic        RegWrite_W,
  output logic [4:0]  WA_W,
  output logic [31:0] WD_W,
  output logic [31:0] wb_count
);

  wb_dec_t     dec;
  logic [31:0] ld_data;
  logic [31:0] wd_raw;
  logic [31:0] rf_q [32];
  logic [31:0] wb_count_d, wb_count_q;
  logic        unused_instr_bits;

  // rs and shamt only matter to earlier stages.
  assign unused_instr_bits = ^{instr_W[25:21], instr_W[10:6]};

  assign dec = decode(instr_W);

  wb_grf_load_ext u_load_ext (
    .ld_type  (dec.ld_type),
    .byte_off (ALUOut_W[1:0]),
    .rdata    (ReadData_W),
    .ld_data  (ld_data)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wd_raw = ALUOut_W;
    case (dec.wdsel)
      WD_MEM:  wd_raw = ld_data;
      WD_PC8:  wd_raw = pc_W + 32'd8;
      default: wd_raw = ALUOut_W;
    endcase
  end

  // A destination of $0 is squashed here, so the array never sees it.
  assign RegWrite_W = dec.we && (dec.wa != 5'd0);
  assign WA_W       = RegWrite_W ? dec.wa : 5'd0;
  assign WD_W       = RegWrite_W ? wd_raw : 32'd0;

  // NOTE: the whole array is cleared on reset because software relies on zeroed registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (RegWrite_W) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      rf_q[WA_W] <= WD_W;
    end
  end

  always_comb begin
    RD1_D = (A1_D == 5'd0) ? 32'd0 : rf_q[A1_D];
    RD2_D = (A2_D == 5'd0) ? 32'd0 : rf_q[A2_D];
`ifdef GRF_BYPASS_EN
    // RegWrite_W implies WA_W != 0, so $0 reads stay zero.
    if (RegWrite_W && (A1_D == WA_W)) RD1_D = WD_W;
    if (RegWrite_W && (A2_D == WA_W)) RD2_D = WD_W;
`endif
  end

  assign wb_count_d = wb_count_q + {31'd0, RegWrite_W};

  always_ff @(posedge clk) begin
    if (!reset) wb_count_q <= 32'd0;
    else        wb_count_q <= wb_count_d;
  end

  assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_grf.sv
// Scoreboard bench for wb_grf: directed test-plan cases followed by random
// instruction traffic, checked against an architectural register-file model.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_W, pc_W, ALUOut_W, ReadData_W;
  logic [4:0]  A1_D, A2_D;
  logic [31:0] RD1_D, RD2_D, WD_W, wb_count;
  logic        RegWrite_W;
  logic [4:0]  WA_W;

  always #5 clk = ~clk;

  wb_grf dut (
    .clk        (clk),
    .reset      (reset),
    .instr_W    (instr_W),
    .pc_W       (pc_W),
    .ALUOut_W   (ALUOut_W),
    .ReadData_W (ReadData_W),
    .A1_D       (A1_D),
    .A2_D       (A2_D),
    .RD1_D      (RD1_D),
    .RD2_D      (RD2_D),
    .RegWrite_W (RegWrite_W),
    .WA_W       (WA_W),
    .WD_W       (WD_W),
    .wb_count   (wb_count)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  bit   [31:0] ref_rf [32];
  bit   [31:0] ref_cnt;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] funct);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Architectural write-back rules expressed directly on the instruction fields.
  function automatic void ref_wb(input bit [31:0] instr, input bit [31:0] pc, input bit [31:0] alu,
                                 input bit [31:0] rdata, output bit we, output bit [4:0] wa,
                                 output bit [31:0] wd);
    bit [5:0] op    = instr[31:26];
    bit [5:0] funct = instr[5:0];
    bit [4:0] rt    = instr[20:16];
    bit [4:0] rd    = instr[15:11];
    int       off   = int'(alu[1:0]);
    bit       w     = 1'b0;
    wa = 5'd0;
    wd = 32'd0;
    case (op)
      6'h00: begin
        if (funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                          6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03}) begin
          w = 1'b1; wa = rd; wd = alu;
        end else if (funct == 6'h09) begin
          w = 1'b1; wa = rd; wd = pc + 32'd8;
        end
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        w = 1'b1; wa = rt; wd = alu;
      end
      6'h20: begin w = 1'b1; wa = rt; wd = 32'($signed(8'(rdata >> (8 * off)))); end
      6'h24: begin w = 1'b1; wa = rt; wd = 32'(8'(rdata >> (8 * off))); end
      6'h21: begin w = 1'b1; wa = rt; wd = 32'($signed(16'(rdata >> (16 * (off / 2))))); end
      6'h25: begin w = 1'b1; wa = rt; wd = 32'(16'(rdata >> (16 * (off / 2)))); end
      6'h23: begin w = 1'b1; wa = rt; wd = rdata; end
      6'h03: begin w = 1'b1; wa = 5'd31; wd = pc + 32'd8; end
      default: ;
    endcase
    we = w && (wa != 5'd0);
    if (!we) begin
      wa = 5'd0;
      wd = 32'd0;
    end
  endfunction

  // Drive one W cycle, push its expected response, then advance the model past the edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [4:0] a1, input logic [4:0] a2,
                       input bit rst_n, input string tag);
    exp_t e;
    bit   we;
    bit [4:0]  wa;
    bit [31:0] wd;
    @(posedge clk);
    #1;
    reset = rst_n; instr_W = instr; pc_W = pc; ALUOut_W = alu; ReadData_W = rdata;
    A1_D = a1; A2_D = a2;
    ref_wb(instr, pc, alu, rdata, we, wa, wd);
    e.we  = we;
    e.wa  = wa;
    e.wd  = wd;
    e.rd1 = ref_rf[a1];
    e.rd2 = ref_rf[a2];
`ifdef GRF_BYPASS_EN
    if (we && a1 == wa) e.rd1 = wd;
    if (we && a2 == wa) e.rd2 = wd;
`endif
    e.cnt = ref_cnt;
    e.tag = tag;
    sb.push_back(e);
    if (!rst_n) begin
      foreach (ref_rf[i]) ref_rf[i] = 32'd0;
      ref_cnt = 32'd0;
    end else if (we) begin
      ref_rf[wa] = wd;
      ref_cnt    = ref_cnt + 32'd1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, ".we"},  {31'd0, RegWrite_W}, {31'd0, e.we});
        check({e.tag, ".wa"},  {27'd0, WA_W}, {27'd0, e.wa});
        check({e.tag, ".wd"},  WD_W, e.wd);
        check({e.tag, ".rd1"}, RD1_D, e.rd1);
        check({e.tag, ".rd2"}, RD2_D, e.rd2);
        check({e.tag, ".cnt"}, wb_count, e.cnt);
      end
    end
  end

  logic [5:0] r_functs [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h01, 6'h18};
  logic [5:0] ld_ops [5]    = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};

  initial begin : stimulus
    logic [31:0] instr;
    logic [4:0]  a1, a2;
    bit          rst_n;
    reset = 1'b0; instr_W = '0; pc_W = '0; ALUOut_W = '0; ReadData_W = '0; A1_D = '0; A2_D = '0;
    foreach (ref_rf[i]) ref_rf[i] = 32'd0;
    ref_cnt = 32'd0;
    repeat (2) @(posedge clk);

    // Reset clears a previously written register and the counter.
    issue(enc_i(6'h0D, 0, 5, 16'h1234), 32'h100, 32'h1234, 32'h0, 5'd5, 5'd0, 1'b1, "wr5");
    issue(32'h0, 32'h104, 32'h0, 32'h0, 5'd5, 5'd0, 1'b0, "rst_a");
    issue(32'h0, 32'h108, 32'h0, 32'h0, 5'd5, 5'd0, 1'b0, "rst_b");
    issue(32'h0, 32'h10C, 32'h0, 32'h0, 5'd5, 5'd5, 1'b1, "post_rst");

    issue(enc_i(6'h0D, 0, 8, 16'hBEEF), 32'h110, 32'h0000BEEF, 32'h0, 5'd0, 5'd8, 1'b1, "ori8");
    issue(32'h0, 32'h114, 32'h0, 32'h0, 5'd0, 5'd8, 1'b1, "rd8");

    issue(enc_r(1, 2, 0, 6'h21), 32'h118, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 1'b1, "wr0");
    issue(32'h0, 32'h11C, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, "rd0");

    issue(enc_i(6'h20, 0, 10, 16'h3), 32'h120, 32'h00000003, 32'h80FF7F01, 5'd0, 5'd0, 1'b1, "lb3");
    issue(enc_i(6'h24, 0, 11, 16'h1), 32'h124, 32'h00000001, 32'h80FF7F01, 5'd10, 5'd0, 1'b1, "lbu1");
    issue(enc_i(6'h21, 0, 12, 16'h2), 32'h128, 32'h00000002, 32'h80FF7F01, 5'd11, 5'd0, 1'b1, "lh2");
    issue(enc_i(6'h25, 0, 13, 16'h0), 32'h12C, 32'h00000000, 32'h80FF7F01, 5'd12, 5'd0, 1'b1, "lhu0");
    issue(enc_i(6'h21, 0, 14, 16'h3), 32'h130, 32'h00000003, 32'h80FF7F01, 5'd13, 5'd0, 1'b1, "lh3");

    issue({6'h03, 26'h0}, 32'h00003000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, "jal");
    issue(enc_r(3, 0, 4, 6'h09), 32'h00004000, 32'h0, 32'h0, 5'd31, 5'd0, 1'b1, "jalr");
    issue(enc_r(31, 0, 7, 6'h08), 32'h00005000, 32'h0, 32'h0, 5'd31, 5'd4, 1'b1, "jr");
    issue(32'h0, 32'h00005004, 32'h0, 32'h0, 5'd7, 5'd4, 1'b1, "rd_jr");

    // Same-cycle read of the register being written.
    issue(enc_i(6'h0D, 0, 9, 16'h1111), 32'h200, 32'h00001111, 32'h0, 5'd0, 5'd0, 1'b1, "pre9");
    issue(enc_r(1, 2, 9, 6'h21), 32'h204, 32'hCAFEF00D, 32'h0, 5'd9, 5'd9, 1'b1, "same9");
    issue(32'h0, 32'h208, 32'h0, 32'h0, 5'd9, 5'd9, 1'b1, "post9");

    repeat (1500) begin
      int cls = int'($urandom_range(0, 9));
      int rt  = int'($urandom_range(0, 7));
      int rd  = int'($urandom_range(0, 7));
      case (cls)
        0:       instr = 32'h0;
        1, 2:    instr = enc_r(int'($urandom_range(0, 31)), rt, rd, r_functs[$urandom_range(0, 16)]);
        3:       instr = enc_i(6'(6'h08 + $urandom_range(0, 7)), 0, rt, 16'($urandom));
        4, 5:    instr = enc_i(ld_ops[$urandom_range(0, 4)], 0, rt, 16'($urandom));
        6:       instr = {6'h03, 26'($urandom)};
        7:       instr = $urandom;
        default: instr = enc_r(1, 2, rd, r_functs[$urandom_range(0, 12)]);
      endcase
      a1    = $urandom_range(0, 1) ? instr[15:11] : 5'($urandom_range(0, 7));
      a2    = $urandom_range(0, 1) ? instr[20:16] : 5'($urandom_range(0, 31));
      rst_n = ($urandom_range(0, 199) != 0);
      issue(instr, $urandom, $urandom, $urandom, a1, a2, rst_n, "rnd");
    end

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_grf.md
# wb_grf

Writeback stage and general register file for the 5-stage pipelined MIPS core. Consumes the W-stage bundle (instruction, PC, ALU result, memory read word) latched by the M/W pipeline register, decodes the destination and write data, and commits the result into a 32×32 register file. Provides two asynchronous read ports to the D stage. Exports the committed write address/data for the hazard/forwarding logic.

## Interface
- No parameters; widths fixed at 32-bit data and 5-bit register index.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-low; sampled on rising `clk`.
- `instr_W` input 32: W-stage instruction word.
- `pc_W` input 32: W-stage instruction address.
- `ALUOut_W` input 32: ALU result; also the load byte address.
- `ReadData_W` input 32: aligned word read from data memory.
- `A1_D` input 5: read port 1 index (rs).
- `A2_D` input 5: read port 2 index (rt).
- `RD1_D` output 32: read port 1 data.
- `RD2_D` output 32: read port 2 data.
- `RegWrite_W` output 1: W-stage instruction commits a register write this cycle.
- `WA_W` output 5: committed destination index; 0 when no write.
- `WD_W` output 32: committed write data.
- `wb_count` output 32: number of committed writes since reset.

## Operation
- Write decode (combinational from `instr_W`):
  - opcode 0x00: write `rd` from ALU for funct add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll/srl/sra; jalr (0x09) writes `rd` with `pc_W+8`; jr (0x08) and all other funct: no write.
  - addi/addiu/andi/ori/xori/lui/slti/sltiu: write `rt` from `ALUOut_W`.
  - lw/lh/lhu/lb/lbu: write `rt` from load extender.
  - jal: write 31 with `pc_W+8`.
  - any other opcode, including instr_W = 0 (nop/bubble): no write.
- Load extender uses `ALUOut_W[1:0]`. Byte lane k = `ReadData_W[8k+7:8k]`. Halfword selects `[15:0]` for offset 0 and `[31:16]` for offset 2. lb/lh sign-extend, lbu/lhu zero-extend. lw passes the word. Misaligned halfword offsets (1, 3) use the lane at offset&2; there is no trap.
- A decoded destination of 0 forces `RegWrite_W`=0, `WA_W`=0, `WD_W`=0. `$0` is never written.
- `RD1_D`/`RD2_D` are combinational reads of the array. Index 0 always reads 0.
- `wb_count` increments by 1 on each edge where `RegWrite_W`=1 and `reset`=1. It wraps 0xFFFFFFFF→0.

## Timing
- Reset: on a rising edge with `reset`=0, all 32 registers and `wb_count` clear to 0. Reads in the following cycle return 0. Reset overrides a concurrent write; that write is lost.
- Write latency: the value appears in the array at the rising edge ending the W cycle. Without the bypass it is visible on the read ports one cycle later.
- Same-index reads on both ports in the same cycle return identical data.
- `RegWrite_W`/`WA_W`/`WD_W` are combinational from the W inputs. They carry no registered delay.
- No handshakes. The block never stalls; bubbles arrive as `instr_W`=0.

## Configuration
- `GRF_BYPASS_EN` defined: internal write-through. If `RegWrite_W`=1 and `A1_D`==`WA_W` (resp. `A2_D`), the read port returns `WD_W` in the same cycle. This removes the W→D forwarding path from the hazard unit.
- Undefined: reads return array contents only. A same-cycle write is not visible until the next cycle, and the hazard unit must forward W→D.

## Structure
- Shared package/header: opcode and funct constants, the WDSel encoding (ALU/MEM/PC8), and the register index constant RA=31.
- One natural sub-module: `load_ext`, the byte/halfword selector and extender, which is combinational. Decode, array, bypass and counter stay in `wb_grf`.

## Test plan
- Reset: hold `reset`=0 for 2 edges after writing 0x1234 to $5 → `RD1_D`(A1=5)=0, `wb_count`=0.
- ori $8,$0,0xBEEF with `ALUOut_W`=0x0000BEEF → next cycle `RD2_D`(A2=8)=0x0000BEEF, `wb_count`=1.
- Write to $0 (addu $0,…, ALUOut=0xFFFFFFFF) → `RegWrite_W`=0, `RD1_D`(A1=0)=0, `wb_count` unchanged.
- Loads with `ReadData_W`=0x80FF7F01:
  - lb, ALUOut[1:0]=3 → 0xFFFFFF80.
  - lbu, offset 1 → 0x7F.
  - lh, offset 2 → 0xFFFF80FF.
  - lhu, offset 0 → 0x7F01.
- jal with `pc_W`=0x00003000 → $31=0x00003008. jalr rd=4 → $4=`pc_W`+8. jr → no write.
- Same-cycle read/write of $9=0xCAFEF00D:
  - with `GRF_BYPASS_EN`, `RD1_D`=0xCAFEF00D in that cycle.
  - without it, `RD1_D` shows the old value, then 0xCAFEF00D next cycle.
